// File: rtl/fifo.sv
// Single-clock 8-bit FIFO with registered read data (normal, non-show-ahead mode).
// The storage is an inferred block RAM. Flags come from one registered occupancy count.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 15,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  sclr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] usedw
);

  localparam int COUNT_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wrPtr;
  logic [ADDR_WIDTH-1:0] rdPtr;
  logic [COUNT_W-1:0]    count;
  logic                  wrOk;
  logic                  rdOk;

  // A read is gated by ~empty, so it can never target the entry being written on the same edge.
  assign wrOk = wrreq & ~full;
  assign rdOk = rdreq & ~empty;

  assign empty = (count == '0);
  assign full  = (count == COUNT_W'(DEPTH));
  assign usedw = count[ADDR_WIDTH-1:0];

  // NOTE: the RAM array has no reset. Keeping it out of the reset block lets it map onto block RAM.
  always_ff @(posedge clock) begin
    if (wrOk) mem[wrPtr] <= data;
  end

  // NOTE: state registers use non-blocking assignments only. All of them then update together on the edge.
  always_ff @(posedge clock or negedge sclr) begin
    if (!sclr) begin
      wrPtr <= '0;
      rdPtr <= '0;
      q     <= '0;
    end else begin
      if (wrOk) wrPtr <= wrPtr + ADDR_WIDTH'(1);
      if (rdOk) begin
        q     <= mem[rdPtr];
        rdPtr <= rdPtr + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge sclr) begin
    if (!sclr) begin
      count <= '0;
    end else begin
      unique case ({wrOk, rdOk})
        2'b10:   count <= count + COUNT_W'(1);
        2'b01:   count <= count - COUNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Directed testbench for fifo. A table of per-cycle vectors is applied first.
// Hand-written fill/wrap/drain sequences follow.
module tb_fifo;

  localparam int DEPTH = 32768;

  logic        clock = 1'b0;
  logic        sclr  = 1'b0;
  logic [7:0]  data  = '0;
  logic        wrreq = 1'b0;
  logic        rdreq = 1'b0;
  logic [7:0]  q;
  logic        empty;
  logic        full;
  logic [14:0] usedw;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        sclrV;
    logic        wr;
    logic        rd;
    logic [7:0]  din;
    logic [7:0]  expQ;
    logic        expEmpty;
    logic        expFull;
    logic [14:0] expUsedw;
  } vec_t;

  vec_t vecs[$];

  fifo dut (
    .clock (clock),
    .sclr  (sclr),
    .data  (data),
    .wrreq (wrreq),
    .rdreq (rdreq),
    .q     (q),
    .empty (empty),
    .full  (full),
    .usedw (usedw)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic s, input logic w, input logic r, input logic [7:0] d,
                        input logic [7:0] eq, input logic ee, input logic ef, input logic [14:0] eu);
    vecs.push_back('{s, w, r, d, eq, ee, ef, eu});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int errs;

    // Reset held for 10 cycles, then released.
    for (int i = 0; i < 10; i++) addVec(0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    addVec(1, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    // Five spaced writes.
    for (int i = 1; i <= 5; i++) begin
      addVec(1, 1, 0, 8'(i), 8'h00, 0, 0, 15'(i));
      addVec(1, 0, 0, 8'h00, 8'h00, 0, 0, 15'(i));
    end
    // Three spaced reads.
    for (int i = 1; i <= 3; i++) begin
      addVec(1, 0, 1, 8'h00, 8'(i), 0, 0, 15'(5 - i));
      addVec(1, 0, 0, 8'h00, 8'(i), 0, 0, 15'(5 - i));
    end
    // One-cycle reset mid-operation, then refill.
    addVec(0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    addVec(1, 1, 0, 8'h51, 8'h00, 0, 0, 1);
    addVec(1, 0, 0, 8'h00, 8'h00, 0, 0, 1);
    addVec(1, 1, 0, 8'h52, 8'h00, 0, 0, 2);
    addVec(1, 1, 0, 8'h53, 8'h00, 0, 0, 3);
    addVec(1, 0, 0, 8'h00, 8'h00, 0, 0, 3);
    // Seven reads: three return data, four underflow and are ignored.
    addVec(1, 0, 1, 8'h00, 8'h51, 0, 0, 2);
    addVec(1, 0, 1, 8'h00, 8'h52, 0, 0, 1);
    addVec(1, 0, 1, 8'h00, 8'h53, 1, 0, 0);
    for (int i = 0; i < 4; i++) addVec(1, 0, 1, 8'h00, 8'h53, 1, 0, 0);
    // Read+write while empty: only the write happens.
    addVec(1, 1, 1, 8'hAA, 8'h53, 0, 0, 1);
    // Read+write while non-empty: both happen, count unchanged.
    addVec(1, 1, 1, 8'hBB, 8'hAA, 0, 0, 1);
    addVec(1, 0, 1, 8'h00, 8'hBB, 1, 0, 0);

    #1;
    check("reset_async_q", q, 8'h00);
    check("reset_async_empty", empty, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      sclr  = vecs[i].sclrV;
      wrreq = vecs[i].wr;
      rdreq = vecs[i].rd;
      data  = vecs[i].din;
      step();
      check($sformatf("vec%0d_q", i), q, vecs[i].expQ);
      check($sformatf("vec%0d_empty", i), empty, vecs[i].expEmpty);
      check($sformatf("vec%0d_full", i), full, vecs[i].expFull);
      check($sformatf("vec%0d_usedw", i), usedw, vecs[i].expUsedw);
    end

    // Start the fill from a clean reset so that entry 0 holds index 0.
    wrreq = 0; rdreq = 0; sclr = 0;
    step();
    sclr = 1;
    step();

    wrreq = 1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      data = 8'(i);
      step();
    end
    check("fill_almost_full", full, 1'b0);
    check("fill_almost_usedw", usedw, 15'd32767);
    data = 8'(DEPTH - 1);
    step();
    check("fill_full", full, 1'b1);
    check("fill_usedw_wrap", usedw, 15'd0);
    check("fill_not_empty", empty, 1'b0);

    // An overflow write is ignored.
    data = 8'hEE;
    step();
    check("overflow_full", full, 1'b1);
    check("overflow_usedw", usedw, 15'd0);
    check("overflow_q", q, 8'h00);

    // Read+write while full: only the read happens.
    data  = 8'hCC;
    rdreq = 1;
    step();
    check("rdwr_full_q", q, 8'h00);
    check("rdwr_full_usedw", usedw, 15'd32767);
    check("rdwr_full_full", full, 1'b0);

    // Drain the rest. The read pointer wraps past DEPTH-1 during the drain.
    wrreq = 0;
    errs  = 0;
    for (int i = 1; i < DEPTH; i++) begin
      step();
      if (q !== 8'(i)) errs++;
    end
    check("drain_sequence_errors", errs, 0);
    check("drain_empty", empty, 1'b1);
    check("drain_usedw", usedw, 15'd0);
    check("drain_last_q", q, 8'hFF);

    step();
    check("underflow_q_hold", q, 8'hFF);
    check("underflow_usedw", usedw, 15'd0);
    rdreq = 0;

    // After the pointer wrap, data written next is read back next.
    wrreq = 1; data = 8'h3C;
    step();
    wrreq = 0; rdreq = 1;
    step();
    rdreq = 0;
    check("post_wrap_q", q, 8'h3C);
    check("post_wrap_empty", empty, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Single-clock, synchronous first-in/first-out buffer: 8-bit data, 32768 entries.
- Functionally equivalent to a vendor single-clock FIFO in normal (non-show-ahead) read mode.
- Decouples byte producers and consumers inside the virtual DS2431 design, e.g. between the 1-Wire byte engine and the host side.
- Storage is inferred block RAM plus pointer/count logic.

Parameters:
DATA_WIDTH, 8, width of data and q
ADDR_WIDTH, 15, pointer and usedw width
DEPTH, 32768 (2**ADDR_WIDTH), number of storage entries

Ports:
clock  input  1  rising-edge system clock
sclr  input  1  asynchronous reset, active-low; sclr=0 clears the FIFO immediately
data  input  8  write data, sampled on the rising edge when wrreq=1
wrreq  input  1  write request, level-sampled each rising edge
rdreq  input  1  read request, level-sampled each rising edge
q  output  8  registered read data
empty  output  1  1 when no entries are stored
full  output  1  1 when DEPTH entries are stored
usedw  output  15  number of stored entries, modulo DEPTH

Behaviour:
- Reset (sclr=0, asynchronous assert, released synchronously to the next edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - q=8'h00, empty=1, full=0, usedw=0.
  - RAM contents are not cleared and are don't-care.
  - A reset mid-operation discards all stored data; the first read after refill returns the first byte written after reset.
- Write acceptance: wr_ok = wrreq & ~full.
  - On the edge: mem[wr_ptr] <= data; wr_ptr <= wr_ptr+1 (wraps DEPTH-1 -> 0).
- Read acceptance: rd_ok = rdreq & ~empty.
  - On the edge: q <= mem[rd_ptr]; rd_ptr <= rd_ptr+1 (wraps).
  - q is valid after that same edge (1-cycle latency from rdreq sampled).
  - q holds its last value whenever no read is accepted, including reads while empty.
- Overflow/underflow: a write while full and a read while empty are silently ignored. Pointers, count and q are unchanged.
- Simultaneous accepted read and write: both are performed and count is unchanged.
  - When empty, only the write is performed; the read is ignored. The first read therefore needs empty=0 on the sampling edge.
  - When full, only the read is performed.
- Count: internal 16-bit count (0..DEPTH), +1 on write only, -1 on read only.
  - usedw = count[14:0], so it reads 0 when full; full disambiguates.
  - empty = (count==0); full = (count==DEPTH).
  - All flags are registered, or derived combinationally from the registered count; they update on the same edge as the transfer.
- No same-address read/write hazard: a read never targets an entry being written on that edge, because reads are gated by ~empty.
- Implementation: dual-pointer RAM, synchronous write and registered read; no combinational path from inputs to outputs.

Test Plan:
- Reset: hold sclr=0 for 10 cycles, release -> empty=1, full=0, usedw=0, q=00.
- Write 01,02,03,04,05 (one-cycle wrreq pulses spaced by idle cycles) -> usedw steps 1..5, empty=0 after the first write.
- Three single-cycle rdreq pulses -> q=01, 02, 03 each one edge after the respective rdreq; usedw=2.
- Pulse sclr=0 for 1 cycle mid-operation -> usedw=0, empty=1, q=00. Then write 51,52,53 -> usedw=3.
- Seven rdreq pulses -> q=51, 52, 53. The remaining four reads are ignored: q stays 53, usedw=0, empty=1.
- Fill with 32768 writes (data=index[7:0]) -> full=1, usedw=0. An extra write is ignored. Simultaneous rd+wr while full -> only the read occurs, q=00, usedw=32767, full=0. Drain all -> sequence intact through pointer wrap.
